// File: rtl/card_request_arbiter.sv
//==============================================================================
// Module      : card_request_arbiter
// Description : Round-robin sharing of one card generator among N_REQ requesters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module card_request_arbiter #(
    parameter int N_REQ       = 4,
    parameter int OWNER_W     = 2,
    parameter int GEN_LATENCY = 2,
    parameter int DECK_SIZE   = 52,
    parameter int CARD_W      = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic               new_deck_i,
    input  logic [CARD_W-1:0]  gen_card_i,
    output logic               gen_request_o,
    output logic [CARD_W-1:0]  card_o,
    output logic               card_valid_o,
    output logic [OWNER_W-1:0] card_owner_o,
    output logic               busy_o,
    output logic               deck_empty_o,
    output logic [5:0]         dealt_cnt_o
);

    localparam int LAT_W = $clog2(GEN_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t             state;
    logic [LAT_W-1:0]   lat_cnt;
    logic [OWNER_W-1:0] rr_ptr;
    logic [OWNER_W-1:0] owner;
    logic [OWNER_W-1:0] pick;
    logic [OWNER_W-1:0] next_rr;
    logic               found;
    int                 idx;

    // First requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = OWNER_W'(idx);
            end
        end
    end

    assign next_rr      = (owner == OWNER_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign busy_o       = (state != IDLE);
    assign deck_empty_o = (dealt_cnt_o == 6'(DECK_SIZE));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            rr_ptr        <= '0;
            owner         <= '0;
            gen_request_o <= 1'b0;
            card_o        <= '0;
            card_valid_o  <= 1'b0;
            card_owner_o  <= '0;
            dealt_cnt_o   <= '0;
        end else begin
            gen_request_o <= 1'b0;
            card_valid_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (found && !deck_empty_o) begin
                        owner         <= pick;
                        gen_request_o <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_W'(GEN_LATENCY - 1);
                    state   <= (GEN_LATENCY == 1) ? DELIVER : WAIT;
                end
                WAIT: begin
                    if (lat_cnt == LAT_W'(1)) begin
                        state <= DELIVER;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DELIVER: begin
                    card_o       <= gen_card_i;
                    card_owner_o <= owner;
                    card_valid_o <= 1'b1;
                    rr_ptr       <= next_rr;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A fresh deck overrides the increment of a coincident delivery.
            if (new_deck_i) begin
                dealt_cnt_o <= '0;
            end else if (state == DELIVER && !deck_empty_o) begin
                dealt_cnt_o <= dealt_cnt_o + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_card_request_arbiter.sv
//==============================================================================
// Module      : tb_card_request_arbiter
// Description : Directed and randomized checks of card_request_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_card_request_arbiter;

    localparam int N_REQ       = 4;
    localparam int OWNER_W     = 2;
    localparam int GEN_LATENCY = 2;
    localparam int DECK_SIZE   = 52;
    localparam int CARD_W      = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_REQ-1:0]   req;
    logic               new_deck;
    logic [CARD_W-1:0]  gen_card;
    logic               gen_request;
    logic [CARD_W-1:0]  card;
    logic               card_valid;
    logic [OWNER_W-1:0] card_owner;
    logic               busy;
    logic               deck_empty;
    logic [5:0]         dealt_cnt;

    always #5 clk = ~clk;

    card_request_arbiter #(
        .N_REQ(N_REQ), .OWNER_W(OWNER_W), .GEN_LATENCY(GEN_LATENCY),
        .DECK_SIZE(DECK_SIZE), .CARD_W(CARD_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .new_deck_i(new_deck),
        .gen_card_i(gen_card), .gen_request_o(gen_request), .card_o(card),
        .card_valid_o(card_valid), .card_owner_o(card_owner), .busy_o(busy),
        .deck_empty_o(deck_empty), .dealt_cnt_o(dealt_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: elapsed cycles since the grant decide every output.
    bit m_active, m_valid, m_genreq;
    int m_t, m_owner, m_rr, m_cnt, m_card, m_vowner;

    task automatic model_edge();
        bit deliver, grant;
        int win;
        if (!rst) begin
            m_active = 0; m_valid = 0; m_genreq = 0;
            m_t = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_card = 0; m_vowner = 0;
            return;
        end
        deliver  = m_active && (m_t == GEN_LATENCY);
        grant    = !m_active && (req != 0) && (m_cnt < DECK_SIZE);
        m_valid  = 0;
        m_genreq = 0;
        if (deliver) begin
            m_valid  = 1;
            m_card   = int'(gen_card);
            m_vowner = m_owner;
            m_rr     = (m_owner + 1) % N_REQ;
            m_active = 0;
            if (m_cnt < DECK_SIZE) m_cnt++;
        end else if (m_active) begin
            m_t++;
        end
        if (grant) begin
            win = -1;
            for (int k = 0; k < N_REQ; k++) begin
                if (win < 0 && req[(m_rr + k) % N_REQ]) win = (m_rr + k) % N_REQ;
            end
            m_owner  = win;
            m_active = 1;
            m_t      = 0;
            m_genreq = 1;
        end
        if (new_deck) m_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("gen_request", 32'(gen_request), 32'(m_genreq));
        check("card_valid",  32'(card_valid),  32'(m_valid));
        check("busy",        32'(busy),        32'(m_active));
        check("deck_empty",  32'(deck_empty),  32'(m_cnt == DECK_SIZE));
        check("dealt_cnt",   32'(dealt_cnt),   m_cnt);
        check("card",        32'(card),        m_card);
        check("card_owner",  32'(card_owner),  m_vowner);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_card(input string tag, output int owner);
        int n;
        n = 0;
        owner = -1;
        while (!card_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(card_valid), 32'd1);
        if (card_valid) owner = int'(card_owner);
    endtask

    initial begin
        int o, n, seen;
        int exp2[5] = '{0, 1, 2, 3, 0};
        rst = 1'b0; req = '0; new_deck = 1'b0; gen_card = '0;

        // Single request: pulse at cycle 1, card at cycle 4.
        do_reset();
        check("rst_dealt", 32'(dealt_cnt), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        req = 4'b0001; gen_card = 8'h15;
        tick();
        check("t1_genreq", 32'(gen_request), 32'd1);
        tick(); tick(); tick();
        check("t1_valid", 32'(card_valid), 32'd1);
        check("t1_card",  32'(card),       32'h15);
        check("t1_owner", 32'(card_owner), 32'd0);
        check("t1_dealt", 32'(dealt_cnt),  32'd1);
        req = '0;
        tick();

        // All requesting: strict rotation.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            gen_card = CARD_W'(8'h40 + i);
            wait_card("t2", o);
            check("t2_order", o, exp2[i]);
            tick();
        end

        // Rotation, not fixed priority.
        do_reset();
        req = 4'b0010;
        wait_card("t3a", o);
        check("t3_first", o, 32'd1);
        req = 4'b0011;
        tick();
        wait_card("t3b", o);
        check("t3_second", o, 32'd0);
        tick();
        wait_card("t3c", o);
        check("t3_third", o, 32'd1);

        // Deck exhaustion and restart.
        do_reset();
        req = 4'b1111;
        n = 0;
        while (dealt_cnt != 6'(DECK_SIZE) && n < 600) begin
            gen_card = CARD_W'($urandom);
            tick();
            n++;
        end
        check("t4_full", 32'(dealt_cnt), 32'(DECK_SIZE));
        check("t4_empty", 32'(deck_empty), 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen += int'(gen_request);
        end
        check("t4_blocked", seen, 32'd0);
        new_deck = 1'b1;
        tick();
        new_deck = 1'b0;
        check("t4_cleared", 32'(dealt_cnt), 32'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen += int'(gen_request);
        end
        check("t4_resume", seen, 32'd1);

        // Reset while waiting on the generator.
        do_reset();
        req = 4'b0100; gen_card = 8'hA5;
        wait_card("t5a", o);
        n = 0;
        while (!(m_active && m_t == 1) && n < 20) begin
            tick();
            n++;
        end
        check("t5_in_wait", 32'(busy), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t5_card",  32'(card),       32'd0);
        check("t5_valid", 32'(card_valid), 32'd0);
        check("t5_busy",  32'(busy),       32'd0);
        req = '0;
        for (int i = 0; i < 4; i++) tick();

        // New deck coincident with delivery at count 10.
        do_reset();
        req = 4'b1111;
        n = 0;
        while (dealt_cnt != 6'd10 && n < 200) begin
            tick();
            n++;
        end
        n = 0;
        while (!(m_active && m_t == GEN_LATENCY) && n < 20) begin
            tick();
            n++;
        end
        new_deck = 1'b1; gen_card = 8'h3C;
        tick();
        new_deck = 1'b0;
        check("t6_valid", 32'(card_valid), 32'd1);
        check("t6_card",  32'(card),       32'h3C);
        check("t6_dealt", 32'(dealt_cnt),  32'd0);

        // Randomized traffic against the model.
        do_reset();
        req = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            gen_card = CARD_W'($urandom);
            new_deck = ($urandom_range(0, 399) == 0);
            rst      = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
            end
            tick();
            if (m_valid && $urandom_range(0, 1) == 1) req[m_vowner] = 1'b0;
            if (m_active && $urandom_range(0, 15) == 0) req[m_owner] = 1'b0;
        end
        rst = 1'b1; new_deck = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
